// File: rtl/demod_shared_mult_pkg.sv
// demod_shared_mult_pkg -- common datapath types for the shared-multiplier
// stage-1 demodulator.
//
// Contents:
//   DATA_W    sample width
//   sample_t  signed sample type used for internal registers
package demod_shared_mult_pkg;

    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/globals_pkg.sv
// globals_pkg -- project-wide fixed-point quantization settings shared by
// every demodulator stage.
//
// Contents:
//   QUANT_BITS    number of fractional bits (1.0 == 1 << QUANT_BITS)
//   QUANT_VAL     numeric value of 1.0 in the quantized domain
//   DEQUANTIZE_I  divide by QUANT_VAL with truncation toward zero, matching
//                 the C reference implementation's integer division
package globals_pkg;

    localparam int QUANT_BITS = 10;
    localparam int QUANT_VAL  = 1 << QUANT_BITS;

    // A plain arithmetic shift rounds toward -inf. Adding (QUANT_VAL - 1) to
    // negative inputs first makes it round toward zero like '/'. The bias
    // cannot overflow because it is only added to negative values.
    function automatic logic signed [31:0] DEQUANTIZE_I(input logic signed [31:0] v);
        logic signed [31:0] bias;
        bias = v[31] ? 32'(QUANT_VAL - 1) : 32'sd0;
        return (v + bias) >>> QUANT_BITS;
    endfunction

endpackage

// File: rtl/demod_mul_deq.sv
// demod_mul_deq -- combinational multiply / truncate / dequantize.
//
// Ports:
//   x, y  in   32s  operands (operand muxing and negation live in the parent)
//   p     out  32s  DEQUANTIZE_I(low 32 bits of x * y)
module demod_mul_deq
    import globals_pkg::*;
(
    input  logic signed [31:0] x,
    input  logic signed [31:0] y,
    output logic signed [31:0] p
);

    // A 32-bit result context keeps only the low word of the product.
    // That low word is exactly the wrapped product of the reference model.
    logic signed [31:0] prod_lo;

    assign prod_lo = x * y;
    assign p       = DEQUANTIZE_I(prod_lo);

endmodule

// File: rtl/demod_shared_mult.sv
// demod_shared_mult -- demodulator stage 1 built around one 32x32 signed
// multiplier that is time-shared over four cycles per sample.
//
// For each sample pair (a = real, b = imag) with the previous pair
// (real_prev, imag_prev) it produces
//   r = DQ(real_prev*a) - DQ(-imag_prev*b)   -> out2 (arctan x)
//   i = DQ(real_prev*b) + DQ(-imag_prev*a)   -> out  (arctan y)
//
// Ports:
//   clock, reset                       clock / synchronous active-high reset
//   inA_rd_en, inA_empty, inA_dout     real-sample FIFO read port
//   inB_rd_en, inB_empty, inB_dout     imag-sample FIFO read port
//   out_wr_en, out_full, out_din       "i" result FIFO write port
//   out2_wr_en, out2_full, out2_din    "r" result FIFO write port
//   sample_count                       completed-sample counter (optional)
//
// Optional feature: define DEMOD_MULT_STATS_EN to add the sample_count port.
module demod_shared_mult
    import globals_pkg::*;
    import demod_shared_mult_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    output logic               inA_rd_en,
    input  logic               inA_empty,
    input  logic signed [31:0] inA_dout,
    output logic               inB_rd_en,
    input  logic               inB_empty,
    input  logic signed [31:0] inB_dout,
    output logic               out_wr_en,
    input  logic               out_full,
    output logic signed [31:0] out_din,
    output logic               out2_wr_en,
    input  logic               out2_full,
    output logic signed [31:0] out2_din
`ifdef DEMOD_MULT_STATS_EN
    ,
    output logic        [31:0] sample_count
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL0  = 3'd1,
        MUL1  = 3'd2,
        MUL2  = 3'd3,
        MUL3  = 3'd4,
        WRITE = 3'd5
    } state_t;

    state_t  state;
    sample_t a, b, acc, r_val, i_val, real_prev, imag_prev;
    sample_t mul_x, mul_y, prod, neg_imag;
    logic    rd_go, wr_go;

    // Handshakes follow the FIFO flags in the same cycle. That timing gives
    // the 5-cycle read-to-write latency and the 6-cycle sample period.
    // Gating with reset keeps both ports quiet while reset is applied.
    assign rd_go = !reset && (state == IDLE)  && !inA_empty && !inB_empty;
    assign wr_go = !reset && (state == WRITE) && !out_full  && !out2_full;

    assign inA_rd_en  = rd_go;
    assign inB_rd_en  = rd_go;
    assign out_wr_en  = wr_go;
    assign out2_wr_en = wr_go;
    assign out_din    = wr_go ? i_val : '0;
    assign out2_din   = wr_go ? r_val : '0;

    // Negation wraps at 32 bits (-(-2^31) == -2^31), like the reference model.
    assign neg_imag = -imag_prev;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        mul_x = real_prev;
        mul_y = a;
        unique case (state)
            MUL1:    begin mul_x = neg_imag;  mul_y = b; end
            MUL2:    begin mul_x = real_prev; mul_y = b; end
            MUL3:    begin mul_x = neg_imag;  mul_y = a; end
            default: ;
        endcase
    end

    demod_mul_deq u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (prod)
    );

    // NOTE: state registers use non-blocking assignments only. All updates
    // then see pre-edge values, whatever order the statements are in.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            acc       <= '0;
            r_val     <= '0;
            i_val     <= '0;
            real_prev <= '0;
            imag_prev <= '0;
`ifdef DEMOD_MULT_STATS_EN
            sample_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rd_go) begin
                        a     <= inA_dout;
                        b     <= inB_dout;
                        state <= MUL0;
                    end
                end
                MUL0: begin
                    acc   <= prod;
                    state <= MUL1;
                end
                MUL1: begin
                    r_val <= acc - prod;
                    state <= MUL2;
                end
                MUL2: begin
                    acc   <= prod;
                    state <= MUL3;
                end
                MUL3: begin
                    i_val     <= acc + prod;
                    real_prev <= a;
                    imag_prev <= b;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (wr_go) begin
                        state <= IDLE;
`ifdef DEMOD_MULT_STATS_EN
                        sample_count <= sample_count + 32'd1;
`endif
                    end
                end
                default: begin
                    // An unreachable encoding means the datapath is suspect.
                    // Restart from a clean history.
                    state     <= IDLE;
                    acc       <= '0;
                    r_val     <= '0;
                    i_val     <= '0;
                    real_prev <= '0;
                    imag_prev <= '0;
                end
            endcase
        end
    end

endmodule
